// File: rtl/bitnet_pkg.sv
// Shared types and constants for the perceptron array control path.
package bitnet_pkg;

  localparam int unsigned LFSR_W = 16;

  // Galois feedback mask for x^16 + x^14 + x^13 + x^11 + 1 (right-shifting form).
  localparam logic [LFSR_W-1:0] LFSR_TAPS = 16'hB400;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LOAD = 3'd1,
    FWD  = 3'd2,
    BWD  = 3'd3,
    DONE = 3'd4
  } seq_state_t;

  // One Galois step: shift right, fold the dropped bit back in at the taps.
  function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] cur);
    lfsr_next = {1'b0, cur[LFSR_W-1:1]} ^ (cur[0] ? LFSR_TAPS : '0);
  endfunction

endpackage

// File: rtl/lfsr16.sv
// 16-bit Galois LFSR that advances only when step is asserted.
module lfsr16
  import bitnet_pkg::*;
#(
  parameter logic [LFSR_W-1:0] SEED = 16'hACE1
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              step,
  output logic [LFSR_W-1:0] state
);

  // Hold the seed under reset, advance one step per enable.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state <= SEED;
    end else if (step) begin
      state <= lfsr_next(state);
    end
  end

endmodule

// File: rtl/prop_sequencer.sv
// Sequences sample fetch and forward/backward propagation strobes for the unit array.
module prop_sequencer
  import bitnet_pkg::*;
#(
  parameter int unsigned       DEPTH       = 4,
  parameter int unsigned       NUM_SAMPLES = 16,
  parameter logic [LFSR_W-1:0] LFSR_SEED   = 16'hACE1
) (
  input  logic clk_in,
  input  logic rst_in,
  input  logic start,
  input  logic train,
  input  logic abort,
  input  logic sample_valid,
  output logic sample_req,
  output logic fd_prop,
  output logic bk_prop,
  output logic oscillator,
  output logic busy,
  output logic done
);

  localparam int unsigned LAYER_W  = $clog2(DEPTH + 1);
  localparam int unsigned SAMPLE_W = $clog2(NUM_SAMPLES + 1);

  seq_state_t          state_q;
  seq_state_t          state_d;
  logic [LAYER_W-1:0]  layer_cnt;
  logic [SAMPLE_W-1:0] sample_cnt;
  logic                mode_train;
  logic                lfsr_step;
  logic                sample_adv;
  logic                layer_last;
  logic                sample_last;
  logic [LFSR_W-1:0]   lfsr_state;

  assign layer_last  = (layer_cnt == LAYER_W'(DEPTH - 1));
  assign sample_last = (sample_cnt == SAMPLE_W'(NUM_SAMPLES - 1));

  lfsr16 #(
    .SEED (LFSR_SEED)
  ) u_lfsr (
    .clk_in (clk_in),
    .rst_in (rst_in),
    .step   (lfsr_step),
    .state  (lfsr_state)
  );

  // The oscillator is the LFSR MSB, which only moves at a sample handshake.
  assign oscillator = lfsr_state[LFSR_W-1];

  // Next-state decode; abort overrides every transition outside IDLE.
  always_comb begin
    state_d    = state_q;
    lfsr_step  = 1'b0;
    sample_adv = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) state_d = LOAD;
      end
      LOAD: begin
        if (sample_valid) begin
          state_d   = FWD;
          lfsr_step = 1'b1;
        end
      end
      FWD: begin
        if (layer_last) begin
          if (mode_train) begin
            state_d = BWD;
          end else if (sample_last) begin
            state_d = DONE;
          end else begin
            state_d    = LOAD;
            sample_adv = 1'b1;
          end
        end
      end
      BWD: begin
        if (layer_last) begin
          if (sample_last) begin
            state_d = DONE;
          end else begin
            state_d    = LOAD;
            sample_adv = 1'b1;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    if (abort && (state_q != IDLE)) begin
      state_d    = IDLE;
      lfsr_step  = 1'b0;
      sample_adv = 1'b0;
    end
  end

  // State register with outputs registered from the next-state decode.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q    <= IDLE;
      sample_req <= 1'b0;
      fd_prop    <= 1'b0;
      bk_prop    <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      state_q    <= state_d;
      sample_req <= (state_d == LOAD);
      fd_prop    <= (state_d == FWD);
      bk_prop    <= (state_d == BWD);
      busy       <= (state_d != IDLE);
      done       <= (state_d == DONE);
    end
  end

  // Layer/sample counters and the train-mode latch.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      layer_cnt  <= '0;
      sample_cnt <= '0;
      mode_train <= 1'b0;
    end else begin
      if (state_q == IDLE) begin
        sample_cnt <= '0;
        mode_train <= train;
      end else if (sample_adv) begin
        sample_cnt <= sample_cnt + SAMPLE_W'(1);
      end
      if (((state_q == FWD) || (state_q == BWD)) && !layer_last && !abort) begin
        layer_cnt <= layer_cnt + LAYER_W'(1);
      end else begin
        layer_cnt <= '0;
      end
    end
  end

  // A nonzero-seeded Galois LFSR can never reach the all-zero lockup state.
  assert property (@(posedge clk_in) disable iff (rst_in) lfsr_state != '0);

endmodule

// File: tb/tb_prop_sequencer.sv
// Self-checking bench for prop_sequencer: vector tables, directed corners, random runs.
module tb_prop_sequencer;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned NSAMP = 2;
  localparam logic [15:0] SEED  = 16'hACE1;

  localparam byte T_L = 8'd1;
  localparam byte T_F = 8'd2;
  localparam byte T_B = 8'd3;
  localparam byte T_D = 8'd4;

  logic clk_in = 1'b0;
  logic rst_in = 1'b1;
  logic start = 1'b0;
  logic train = 1'b0;
  logic abort = 1'b0;
  logic sample_valid = 1'b0;
  logic sample_req, fd_prop, bk_prop, oscillator, busy, done;

  int n_chk = 0;
  int n_pass = 0;

  prop_sequencer #(
    .DEPTH       (DEPTH),
    .NUM_SAMPLES (NSAMP),
    .LFSR_SEED   (SEED)
  ) dut (
    .clk_in       (clk_in),
    .rst_in       (rst_in),
    .start        (start),
    .train        (train),
    .abort        (abort),
    .sample_valid (sample_valid),
    .sample_req   (sample_req),
    .fd_prop      (fd_prop),
    .bk_prop      (bk_prop),
    .oscillator   (oscillator),
    .busy         (busy),
    .done         (done)
  );

  always #5 clk_in = ~clk_in;

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
  endtask

  // Polynomial LFSR reference built from the exponent list of the feedback polynomial.
  function automatic logic [15:0] poly_step(input logic [15:0] s);
    int exps [4];
    logic [15:0] mask;
    exps = '{16, 14, 13, 11};
    mask = 16'h0;
    foreach (exps[i]) mask[exps[i]-1] = 1'b1;
    return s[0] ? ((s >> 1) ^ mask) : (s >> 1);
  endfunction

  // Reference model: a run is a programme of per-cycle tokens consumed one per cycle,
  // except a load token, which stays until the sample handshake.
  byte         prog[$];
  logic [15:0] m_lfsr;

  always @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      prog.delete();
      m_lfsr <= SEED;
    end else if (prog.size() == 0) begin
      if (start) begin
        for (int s = 0; s < int'(NSAMP); s++) begin
          prog.push_back(T_L);
          for (int d = 0; d < int'(DEPTH); d++) prog.push_back(T_F);
          if (train) for (int d = 0; d < int'(DEPTH); d++) prog.push_back(T_B);
        end
        prog.push_back(T_D);
      end
    end else if (abort) begin
      prog.delete();
    end else if (prog[0] == T_L) begin
      if (sample_valid) begin
        void'(prog.pop_front());
        m_lfsr <= poly_step(m_lfsr);
      end
    end else begin
      void'(prog.pop_front());
    end
  end

  function automatic byte head();
    return (prog.size() > 0) ? prog[0] : 8'd0;
  endfunction

  int   run_fd = 0;
  int   run_bk = 0;
  int   fd_rises = 0;
  logic burst_cut = 1'b0;

  // Every-cycle comparison against the model, plus strobe exclusivity and burst lengths.
  always @(negedge clk_in) begin
    byte h;
    h = head();
    chk("m_req",  16'(sample_req), 16'(h == T_L));
    chk("m_fd",   16'(fd_prop),    16'(h == T_F));
    chk("m_bk",   16'(bk_prop),    16'(h == T_B));
    chk("m_done", 16'(done),       16'(h == T_D));
    chk("m_busy", 16'(busy),       16'(prog.size() != 0));
    chk("m_osc",  16'(oscillator), 16'(m_lfsr[15]));
    chk("fd_bk_excl", 16'(fd_prop & bk_prop), 16'h0);
    if (fd_prop) begin
      if (run_fd == 0) fd_rises++;
      run_fd++;
    end else if (run_fd > 0) begin
      if (!burst_cut) chk("fd_burst_len", 16'(run_fd), 16'(DEPTH));
      burst_cut = 1'b0;
      run_fd = 0;
    end
    if (bk_prop) begin
      run_bk++;
    end else if (run_bk > 0) begin
      if (!burst_cut) chk("bk_burst_len", 16'(run_bk), 16'(DEPTH));
      burst_cut = 1'b0;
      run_bk = 0;
    end
  end

  typedef struct {
    logic       start;
    logic       train;
    logic       valid;
    logic [4:0] exp;   // {sample_req, fd_prop, bk_prop, done, busy}
  } vec_t;

  vec_t tbl_inf[$];
  vec_t tbl_trn[$];

  task automatic cyc();
    @(negedge clk_in);
  endtask

  task automatic pulse_start(input logic tr);
    start = 1'b1;
    train = tr;
    cyc();
    start = 1'b0;
  endtask

  task automatic wait_idle(input int bound);
    int k;
    k = 0;
    while (busy && k < bound) begin
      cyc();
      k++;
    end
    chk("idle_timeout", 16'(busy), 16'h0);
  endtask

  task automatic run_table(input string nm, input vec_t t[$]);
    foreach (t[i]) begin
      start = t[i].start;
      train = t[i].train;
      sample_valid = t[i].valid;
      cyc();
      chk($sformatf("%s_row%0d", nm, i),
          16'({sample_req, fd_prop, bk_prop, done, busy}), 16'(t[i].exp));
    end
    start = 1'b0;
  endtask

  initial begin
    logic osc0;
    int   n;
    vec_t v;

    // Inference run, valid tied high: req, 4 fwd, req, 4 fwd, done, idle.
    v = '{1'b1, 1'b0, 1'b1, 5'b10001}; tbl_inf.push_back(v);
    for (int s = 0; s < 2; s++) begin
      if (s == 1) begin v = '{1'b0, 1'b0, 1'b1, 5'b10001}; tbl_inf.push_back(v); end
      for (int d = 0; d < 4; d++) begin v = '{1'b0, 1'b0, 1'b1, 5'b01001}; tbl_inf.push_back(v); end
    end
    v = '{1'b0, 1'b0, 1'b1, 5'b00011}; tbl_inf.push_back(v);
    v = '{1'b0, 1'b0, 1'b1, 5'b00000}; tbl_inf.push_back(v);

    // Train run: each sample is req, 4 fwd, 4 bwd; then done, idle.
    for (int s = 0; s < 2; s++) begin
      v = '{(s == 0), 1'b1, 1'b1, 5'b10001}; tbl_trn.push_back(v);
      for (int d = 0; d < 4; d++) begin v = '{1'b0, 1'b0, 1'b1, 5'b01001}; tbl_trn.push_back(v); end
      for (int d = 0; d < 4; d++) begin v = '{1'b0, 1'b0, 1'b1, 5'b00101}; tbl_trn.push_back(v); end
    end
    v = '{1'b0, 1'b0, 1'b1, 5'b00011}; tbl_trn.push_back(v);
    v = '{1'b0, 1'b0, 1'b1, 5'b00000}; tbl_trn.push_back(v);

    // Reset state.
    repeat (2) cyc();
    chk("rst_outs", 16'({sample_req, fd_prop, bk_prop, done, busy}), 16'h0);
    chk("rst_osc", 16'(oscillator), 16'(SEED[15]));
    rst_in = 1'b0;
    cyc();

    run_table("inf", tbl_inf);
    run_table("trn", tbl_trn);

    // Valid withheld for 7 cycles: request held, no strobes, oscillator frozen.
    sample_valid = 1'b0;
    pulse_start(1'b0);
    osc0 = oscillator;
    for (int i = 0; i < 7; i++) begin
      chk("hold_req", 16'(sample_req), 16'h1);
      chk("hold_strobes", 16'({fd_prop, bk_prop}), 16'h0);
      chk("hold_osc", 16'(oscillator), 16'(osc0));
      if (i < 6) cyc();
    end
    sample_valid = 1'b1;
    cyc();
    chk("hold_fd_after", 16'(fd_prop), 16'h1);
    wait_idle(100);

    // Abort on the third forward cycle, then a full restart.
    pulse_start(1'b0);
    n = 0;
    for (int k = 0; k < 20 && n < 3; k++) begin
      cyc();
      if (fd_prop) n++;
    end
    chk("abort_reach_fd3", 16'(n), 16'd3);
    abort = 1'b1;
    burst_cut = 1'b1;
    cyc();
    abort = 1'b0;
    chk("abort_fd", 16'(fd_prop), 16'h0);
    chk("abort_busy", 16'(busy), 16'h0);
    chk("abort_done", 16'(done), 16'h0);
    fd_rises = 0;
    pulse_start(1'b0);
    wait_idle(100);
    chk("restart_bursts", 16'(fd_rises), 16'(NSAMP));

    // Asynchronous reset during the backward phase.
    pulse_start(1'b1);
    n = 0;
    for (int k = 0; k < 40 && n < 2; k++) begin
      cyc();
      if (bk_prop) n++;
    end
    chk("rst_reach_bwd", 16'(n), 16'd2);
    #2;
    rst_in = 1'b1;
    burst_cut = 1'b1;
    #1;
    chk("async_rst_outs", 16'({sample_req, fd_prop, bk_prop, done, busy}), 16'h0);
    chk("async_rst_osc", 16'(oscillator), 16'(SEED[15]));
    cyc();
    rst_in = 1'b0;
    cyc();

    // Random runs with ragged valid and stray starts while busy.
    for (int r = 0; r < 10; r++) begin
      fd_rises = 0;
      sample_valid = 1'($urandom_range(0, 1));
      pulse_start(1'($urandom_range(0, 1)));
      for (int k = 0; k < 500; k++) begin
        sample_valid = ($urandom_range(0, 3) != 0);
        start = ($urandom_range(0, 15) == 0);
        cyc();
        if (!busy) break;
      end
      start = 1'b0;
      chk("run_timeout", 16'(busy), 16'h0);
      chk("run_bursts", 16'(fd_rises), 16'(NSAMP));
    end

    cyc();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
